// File: rtl/sdcard_dma_sched.sv
// Arbitrates the shared SD-card DMA byte stream between the IDE sector buffer and the CDDA ring buffer.
// Optional macro SDDMA_CDDA_PRIO_EN: CDDA wins every IDLE tie instead of round-robin.
//
// state | meaning
// IDLE  | no owner, waiting for a block request
// GRANT | owner chosen, cpu_irq high, waiting for the AVR to start the read
// XFER  | bytes streaming to the owner, counted and watched by the timeout timer
// DONE  | block complete, owner done pulse high for this cycle
module sdcard_dma_sched #(
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ide_req,
  input  logic       cdda_req,
  output logic       ide_grant,
  output logic       cdda_grant,
  output logic       ide_done,
  output logic       cdda_done,
  input  logic [7:0] dma_data,
  input  logic [8:0] dma_addr,
  input  logic       dma_strobe,
  output logic [7:0] out_dma_data,
  output logic [8:0] out_dma_addr,
  output logic       ide_dma_strobe,
  output logic       cdda_dma_strobe,
  input  logic       cpu_start,
  input  logic       cpu_abort,
  input  logic       cpu_clr_err,
  output logic       cpu_irq,
  output logic [1:0] owner,
  output logic [2:0] err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMR_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TMR_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [9:0] LAST_IDX = 10'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          last_cdda_q, last_cdda_d;
  logic [9:0]    count_q, count_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    err_q, err_d;
  logic          irq_q, irq_d;
  logic          ide_done_q, ide_done_d;
  logic          cdda_done_q, cdda_done_d;
  logic          ide_stb_q, ide_stb_d;
  logic          cdda_stb_q, cdda_stb_d;
  logic [7:0]    data_q, data_d;
  logic [8:0]    addr_q, addr_d;

  logic pick_cdda;
  logic owner_req;
  logic stb_route;
  logic stb_stray;
  logic seq_set;
  logic tmo_set;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_cdda_d = last_cdda_q;
    count_d     = count_q;
    tmr_d       = tmr_q;
    data_d      = data_q;
    addr_d      = addr_q;
    ide_done_d  = 1'b0;
    cdda_done_d = 1'b0;
    tmo_set     = 1'b0;

`ifdef SDDMA_CDDA_PRIO_EN
    pick_cdda = cdda_req;
`else
    pick_cdda = cdda_req && (!ide_req || !last_cdda_q);
`endif

    owner_req = owner_q[0] ? ide_req : cdda_req;
    // An abort on the same cycle as a strobe cancels that byte too.
    stb_route = dma_strobe && (state_q == S_XFER) && !cpu_abort;
    stb_stray = dma_strobe && (state_q != S_XFER);
    seq_set   = stb_route && (dma_addr != count_q[8:0]);

    if (dma_strobe) begin
      data_d = dma_data;
      addr_d = dma_addr;
    end

    case (state_q)
      S_IDLE: begin
        if (ide_req || cdda_req) begin
          state_d     = S_GRANT;
          owner_d     = pick_cdda ? 2'b10 : 2'b01;
          last_cdda_d = pick_cdda;
        end
      end
      S_GRANT: begin
        if (cpu_abort) begin
          state_d = S_IDLE;
          owner_d = 2'b00;
        end else if (cpu_start) begin
          state_d = S_XFER;
          count_d = 10'd0;
          tmr_d   = TMR_LOAD;
        end else if (!owner_req) begin
          state_d = S_IDLE;
          owner_d = 2'b00;
        end
      end
      S_XFER: begin
        if (cpu_abort) begin
          state_d = S_IDLE;
          owner_d = 2'b00;
        end else if (stb_route) begin
          count_d = count_q + 10'd1;
          tmr_d   = TMR_LOAD;
          if (count_q == LAST_IDX) begin
            state_d     = S_DONE;
            ide_done_d  = owner_q[0];
            cdda_done_d = owner_q[1];
          end
        end else if (TMR_EN && (tmr_q == '0)) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
          owner_d = 2'b00;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = 2'b00;
      end
    endcase

    irq_d      = (state_d == S_GRANT);
    ide_stb_d  = stb_route && owner_q[0];
    cdda_stb_d = stb_route && owner_q[1];

    // Setting wins over a same-cycle clear.
    err_d = cpu_clr_err ? 3'b000 : err_q;
    err_d = err_d | {tmo_set, seq_set, stb_stray};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'b00;
      last_cdda_q <= 1'b1;
      count_q     <= 10'd0;
      tmr_q       <= '0;
      err_q       <= 3'b000;
      irq_q       <= 1'b0;
      ide_done_q  <= 1'b0;
      cdda_done_q <= 1'b0;
      ide_stb_q   <= 1'b0;
      cdda_stb_q  <= 1'b0;
      data_q      <= 8'd0;
      addr_q      <= 9'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_cdda_q <= last_cdda_d;
      count_q     <= count_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      ide_done_q  <= ide_done_d;
      cdda_done_q <= cdda_done_d;
      ide_stb_q   <= ide_stb_d;
      cdda_stb_q  <= cdda_stb_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
    end
  end

  assign ide_grant       = owner_q[0];
  assign cdda_grant      = owner_q[1];
  assign owner           = owner_q;
  assign cpu_irq         = irq_q;
  assign ide_done        = ide_done_q;
  assign cdda_done       = cdda_done_q;
  assign ide_dma_strobe  = ide_stb_q;
  assign cdda_dma_strobe = cdda_stb_q;
  assign out_dma_data    = data_q;
  assign out_dma_addr    = addr_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sdcard_dma_sched.sv
// Scoreboard bench for sdcard_dma_sched: directed vectors push expected strobes/done pulses,
// a negedge monitor pops and compares them; static outputs are checked inline.
module tb_sdcard_dma_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ide_req = 1'b0, cdda_req = 1'b0;
  logic       ide_grant, cdda_grant, ide_done, cdda_done;
  logic [7:0] dma_data = 8'd0;
  logic [8:0] dma_addr = 9'd0;
  logic       dma_strobe = 1'b0;
  logic [7:0] out_dma_data;
  logic [8:0] out_dma_addr;
  logic       ide_dma_strobe, cdda_dma_strobe;
  logic       cpu_start = 1'b0, cpu_abort = 1'b0, cpu_clr_err = 1'b0;
  logic       cpu_irq;
  logic [1:0] owner;
  logic [2:0] err;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [1:0] kind;
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  sdcard_dma_sched #(.BLOCK_BYTES(512), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .ide_req(ide_req), .cdda_req(cdda_req),
    .ide_grant(ide_grant), .cdda_grant(cdda_grant),
    .ide_done(ide_done), .cdda_done(cdda_done),
    .dma_data(dma_data), .dma_addr(dma_addr), .dma_strobe(dma_strobe),
    .out_dma_data(out_dma_data), .out_dma_addr(out_dma_addr),
    .ide_dma_strobe(ide_dma_strobe), .cdda_dma_strobe(cdda_dma_strobe),
    .cpu_start(cpu_start), .cpu_abort(cpu_abort), .cpu_clr_err(cpu_clr_err),
    .cpu_irq(cpu_irq), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [8:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // route: 0 = IDE, 1 = CDDA, -1 = not forwarded
  task automatic strobe(input logic [8:0] a, input logic [7:0] d, input int route);
    if (route == 0) push(2'd0, a, d);
    else if (route == 1) push(2'd1, a, d);
    dma_strobe = 1'b1;
    dma_addr   = a;
    dma_data   = d;
    tick();
    dma_strobe = 1'b0;
  endtask

  task automatic run_block(input int route);
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    chk("irq_low_in_xfer", {31'd0, cpu_irq}, 32'd0);
    for (int i = 0; i < 512; i++) strobe(9'(i), 8'(i * 3 + route), route);
    push((route == 0) ? 2'd2 : 2'd3, 9'd0, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic mon_pop(input logic [1:0] k, input logic [8:0] a, input logic [7:0] d);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL monitor: unexpected output kind %0d addr %0d, queue empty", k, a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind === k && e.addr === a && e.data === d) n_pass++;
      else $display("FAIL monitor: got kind %0d addr %0d data %0h expected kind %0d addr %0d data %0h",
                    k, a, d, e.kind, e.addr, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (ide_dma_strobe) mon_pop(2'd0, out_dma_addr, out_dma_data);
    if (cdda_dma_strobe) mon_pop(2'd1, out_dma_addr, out_dma_data);
    if (ide_done) mon_pop(2'd2, 9'd0, 8'd0);
    if (cdda_done) mon_pop(2'd3, 9'd0, 8'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r1;
    logic [1:0] o1;
`ifdef SDDMA_CDDA_PRIO_EN
    r1 = 1;
    o1 = 2'b10;
`else
    r1 = 0;
    o1 = 2'b01;
`endif

    #1;
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_outputs", {24'd0, ide_grant, cdda_grant, ide_done, cdda_done,
                        ide_dma_strobe, cdda_dma_strobe, cpu_irq, 1'b0}, 32'd0);
    chk("rst_err", {29'd0, err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single IDE block
    ide_req = 1'b1;
    tick();
    chk("t1_owner", {30'd0, owner}, 32'd1);
    chk("t1_grants", {30'd0, ide_grant, cdda_grant}, 32'b10);
    chk("t1_irq", {31'd0, cpu_irq}, 32'd1);
    run_block(0);
    ide_req = 1'b0;
    tick();
    chk("t1_owner_after", {30'd0, owner}, 32'd0);
    chk("t1_err", {29'd0, err}, 32'd0);

    // both requests across two blocks
    do_reset();
    ide_req  = 1'b1;
    cdda_req = 1'b1;
    tick();
    chk("t2_first_owner", {30'd0, owner}, {30'd0, o1});
    run_block(r1);
    tick();
    chk("t2_idle_gap", {30'd0, owner}, 32'd0);
    tick();
    chk("t2_second_owner", {30'd0, owner}, 32'd2);
    chk("t2_second_grant", {30'd0, ide_grant, cdda_grant}, 32'b01);
    run_block(1);
    ide_req  = 1'b0;
    cdda_req = 1'b0;
    tick();
    chk("t2_owner_after", {30'd0, owner}, 32'd0);

    // address sequence error
    ide_req = 1'b1;
    tick();
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    strobe(9'd0, 8'h11, 0);
    strobe(9'd1, 8'h22, 0);
    strobe(9'd3, 8'h33, 0);
    chk("t3_seq_err", {29'd0, err}, 32'b010);
    cpu_clr_err = 1'b1;
    tick();
    cpu_clr_err = 1'b0;
    chk("t3_clr", {29'd0, err}, 32'd0);
    ide_req   = 1'b0;
    cpu_abort = 1'b1;
    tick();
    cpu_abort = 1'b0;
    chk("t3_abort_owner", {30'd0, owner}, 32'd0);

    // abort after 100 strobes, then stray
    ide_req = 1'b1;
    tick();
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    for (int i = 0; i < 100; i++) strobe(9'(i), 8'(i + 7), 0);
    ide_req   = 1'b0;
    cpu_abort = 1'b1;
    tick();
    cpu_abort = 1'b0;
    chk("t4_abort_owner", {30'd0, owner}, 32'd0);
    chk("t4_abort_err", {29'd0, err}, 32'd0);
    strobe(9'd100, 8'hEE, -1);
    chk("t4_stray", {29'd0, err}, 32'b001);
    cpu_clr_err = 1'b1;
    tick();
    cpu_clr_err = 1'b0;

    // timeout with no strobes
    cdda_req = 1'b1;
    tick();
    chk("t5_owner", {30'd0, owner}, 32'd2);
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    cdda_req  = 1'b0;
    repeat (63) tick();
    chk("t5_before_tmo_owner", {30'd0, owner}, 32'd2);
    chk("t5_before_tmo_err", {29'd0, err}, 32'd0);
    tick();
    chk("t5_tmo_owner", {30'd0, owner}, 32'd0);
    chk("t5_tmo_err", {29'd0, err}, 32'b100);
    cpu_clr_err = 1'b1;
    tick();
    cpu_clr_err = 1'b0;

    // reset in the middle of a transfer
    ide_req = 1'b1;
    tick();
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    for (int i = 0; i < 10; i++) strobe(9'(i), 8'(i + 40), 0);
    dma_strobe = 1'b1;
    dma_addr   = 9'd10;
    dma_data   = 8'h99;
    @(posedge clk);
    #3;
    rst = 1'b1;
    dma_strobe = 1'b0;
    #1;
    chk("t6_rst_strobe", {30'd0, ide_dma_strobe, cdda_dma_strobe}, 32'd0);
    chk("t6_rst_owner", {29'd0, owner, ide_grant}, 32'd0);
    chk("t6_rst_addr", {23'd0, out_dma_addr}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_regrant", {30'd0, owner}, 32'd1);
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    strobe(9'd0, 8'h01, 0);
    strobe(9'd1, 8'h02, 0);
    strobe(9'd2, 8'h03, 0);
    chk("t6_count_restart", {29'd0, err}, 32'd0);
    ide_req   = 1'b0;
    cpu_abort = 1'b1;
    tick();
    cpu_abort = 1'b0;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
